alu: RTL and testbench
======================

# alu

Single-cycle-decode, registered-output 32-bit integer ALU for the MIPS-style datapath. It takes the raw 32-bit instruction word plus the two register-file operands, and decodes opcode/funct/shamt/immediate internally. It computes the result, zero/overflow/negative flags and the HI/LO multiply-divide pair. All outputs are registered and appear one clock after the inputs are sampled.

## Interface
Parameters: none (width fixed at 32).
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- i_datain  input  32  instruction word: opcode [31:26], shamt [10:6], funct [5:0], imm [15:0]
- gr1  input  32  operand A (rs value); also the value shifted by shift ops
- gr2  input  32  operand B (rt value), R-type only
- c  output  32  registered result
- zon  output  3  registered flags: [2]=zero, [1]=overflow, [0]=negative
- hi  output  32  registered HI (mult high word / div remainder)
- lo  output  32  registered LO (mult low word / div quotient)

## Operation
- Internal operands: reg_A = gr1. reg_B = gr2 for R-type (opcode 0), else the immediate.
- Immediate is sign-extended for addi/addiu/slti/sltiu/beq/bne/lw/sw. It is zero-extended for andi/ori/xori.
- R-type by funct:
  - 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor
  - 0x2A slt (signed), 0x2B sltu; result is 1 or 0
  - 0x00 sll, 0x02 srl, 0x03 sra: shift gr1 by shamt
  - 0x04 sllv, 0x06 srlv, 0x07 srav: shift gr1 by gr2[4:0]
  - 0x18 mult (signed), 0x19 multu: {hi,lo} = 64-bit product
  - 0x1A div (signed), 0x1B divu: lo = quotient, hi = remainder; signed division truncates toward zero, remainder takes the dividend's sign
- I-type by opcode:
  - 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu, 0x0C andi, 0x0D ori, 0x0E xori
  - 0x0F lui: c = {imm,16'h0}
  - 0x04 beq, 0x05 bne: c = A−B
  - 0x23 lw, 0x2B sw: c = A+signext(imm)
- Divide by zero: lo = 32'hFFFF_FFFF, hi = dividend. No flag is raised.
- For mult/div, c = new lo value.
- hi/lo change only on mult/multu/div/divu; they hold on all other instructions.
- Flags are computed from the c being loaded:
  - zero = (c==0)
  - negative = c[31]
  - overflow = signed two's-complement overflow, only for add/addi/sub (and the beq/bne subtraction); 0 for all other ops, including the unsigned variants
- Unsupported opcode/funct: c = 0, zon = 3'b100, hi/lo hold.

## Timing
- Inputs are sampled on each rising clk edge; outputs update on that same edge. Latency is 1 cycle and a new instruction is accepted every cycle. There is no handshake and no stall.
- Multiply and divide are combinational within the single cycle; no multi-cycle sequencer.
- rst asserted: c, zon, hi and lo are cleared to 0 immediately, regardless of clk. They stay 0 while rst is high.
- The first update after rst deasserts happens at the next rising clk edge.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ADDI, …)
  - funct localparams (FN_ADD, FN_SLL, …)
  - flag bit indices (ZON_ZERO=2, ZON_OVF=1, ZON_NEG=0)
- One sub-module, alu_core: purely combinational, takes reg_A, reg_B, shamt, op select; returns result, flags, the 64-bit hi/lo candidate, and a hi/lo write-enable.
- The top level alu does decode, immediate extension and the output registers.

## Test plan
- sll: i_datain=0x00011040 (shamt 1), gr1=0xDDDDDDDD → next edge c=0xBBBBBBBA, zon=3'b001. With i_datain=0x00011080 (shamt 2) → c=0x77777774, zon=3'b000.
- sll into sign bit / by 4: gr1=0x40404040, shamt 1 → c=0x80808080, zon=3'b001. gr1=0x40406040, i_datain=0x00011100 (shamt 4) → c=0x04060400.
- add: i_datain=0x00000020, gr1=0xC0404040, gr2=0xFFFFFFFF → c=0xC040403F, zon=3'b001. gr1=0x7FFFFFFF, gr2=1 → c=0x80000000, zon=3'b011.
- addi: i_datain=0x200000D0, gr1=1 → c=0x000000D1 (209), zon=3'b000. sub with gr1=gr2=5 → c=0, zon=3'b100.
- mult/div:
  - mult gr1=−2, gr2=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA
  - div gr1=−7, gr2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF
  - divu by 0 → lo=0xFFFFFFFF, hi=gr1
  - a following add leaves hi/lo unchanged
- reset: assert rst asynchronously mid-cycle after a mult → c, zon, hi, lo read 0 before the next edge. They remain 0 until the first edge after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared decode constants and internal operation select for the 32-bit ALU.
package alu_pkg;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction bits [5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // Bit positions inside the zon flag vector
    localparam int ZON_ZERO = 2;
    localparam int ZON_OVF  = 1;
    localparam int ZON_NEG  = 0;

    // Operation select passed from decode to the datapath core.
    // Signed add/sub are the only selects that can report overflow.
    typedef enum logic [4:0] {
        ALU_INV   = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_ADDU  = 5'd2,
        ALU_SUB   = 5'd3,
        ALU_SUBU  = 5'd4,
        ALU_AND   = 5'd5,
        ALU_OR    = 5'd6,
        ALU_XOR   = 5'd7,
        ALU_NOR   = 5'd8,
        ALU_SLT   = 5'd9,
        ALU_SLTU  = 5'd10,
        ALU_SLL   = 5'd11,
        ALU_SRL   = 5'd12,
        ALU_SRA   = 5'd13,
        ALU_MULT  = 5'd14,
        ALU_MULTU = 5'd15,
        ALU_DIV   = 5'd16,
        ALU_DIVU  = 5'd17,
        ALU_LUI   = 5'd18
    } alu_sel_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational datapath: arithmetic, logic, shifts, multiply/divide and flags.
module alu_core
    import alu_pkg::*;
(
    input  logic [31:0] reg_a,
    input  logic [31:0] reg_b,
    input  logic [4:0]  shamt,
    input  logic [4:0]  sel,
    output logic [31:0] result,
    output logic [2:0]  zon,
    output logic [63:0] hilo,
    output logic        hilo_we
);

    logic [31:0]        sum;
    logic [31:0]        diff;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        div_b_s;
    logic [31:0]        div_b_u;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic               ovf;

    // Shared adders, multipliers and dividers; divisors are forced to 1 in the
    // divide-by-zero and INT_MIN/-1 cases so the dividers never see an undefined
    // operation, and those cases are patched in the select logic below.
    always_comb begin
        sum      = reg_a + reg_b;
        diff     = reg_a - reg_b;
        prod_s   = $signed({{32{reg_a[31]}}, reg_a}) * $signed({{32{reg_b[31]}}, reg_b});
        prod_u   = {32'd0, reg_a} * {32'd0, reg_b};
        div_zero = (reg_b == 32'd0);
        div_ovf  = (reg_a == 32'h8000_0000) && (reg_b == 32'hFFFF_FFFF);
        div_b_s  = (div_zero || div_ovf) ? 32'd1 : reg_b;
        div_b_u  = div_zero ? 32'd1 : reg_b;
        quot_s   = $signed(reg_a) / $signed(div_b_s);
        rem_s    = $signed(reg_a) % $signed(div_b_s);
        quot_u   = reg_a / div_b_u;
        rem_u    = reg_a % div_b_u;
    end

    // Result / hi-lo candidate selection; for mult/div the result mirrors the new lo
    always_comb begin
        result  = 32'd0;
        hilo    = 64'd0;
        hilo_we = 1'b0;
        ovf     = 1'b0;
        case (sel)
            ALU_ADD: begin
                result = sum;
                ovf    = (reg_a[31] == reg_b[31]) && (sum[31] != reg_a[31]);
            end
            ALU_ADDU: result = sum;
            ALU_SUB: begin
                result = diff;
                ovf    = (reg_a[31] != reg_b[31]) && (diff[31] != reg_a[31]);
            end
            ALU_SUBU: result = diff;
            ALU_AND:  result = reg_a & reg_b;
            ALU_OR:   result = reg_a | reg_b;
            ALU_XOR:  result = reg_a ^ reg_b;
            ALU_NOR:  result = ~(reg_a | reg_b);
            ALU_SLT:  result = {31'd0, ($signed(reg_a) < $signed(reg_b))};
            ALU_SLTU: result = {31'd0, (reg_a < reg_b)};
            ALU_SLL:  result = reg_a << shamt;
            ALU_SRL:  result = reg_a >> shamt;
            ALU_SRA:  result = $signed(reg_a) >>> shamt;
            ALU_LUI:  result = {reg_b[15:0], 16'h0000};
            ALU_MULT: begin
                hilo    = prod_s;
                hilo_we = 1'b1;
                result  = hilo[31:0];
            end
            ALU_MULTU: begin
                hilo    = prod_u;
                hilo_we = 1'b1;
                result  = hilo[31:0];
            end
            ALU_DIV: begin
                hilo_we = 1'b1;
                if (div_zero)
                    hilo = {reg_a, 32'hFFFF_FFFF};
                else if (div_ovf)
                    hilo = {32'd0, 32'h8000_0000};
                else
                    hilo = {rem_s, quot_s};
                result = hilo[31:0];
            end
            ALU_DIVU: begin
                hilo_we = 1'b1;
                if (div_zero)
                    hilo = {reg_a, 32'hFFFF_FFFF};
                else
                    hilo = {rem_u, quot_u};
                result = hilo[31:0];
            end
            default: result = 32'd0;
        endcase
    end

    // Flags derived from the result being loaded
    always_comb begin
        zon           = 3'b000;
        zon[ZON_ZERO] = (result == 32'd0);
        zon[ZON_OVF]  = ovf;
        zon[ZON_NEG]  = result[31];
    end

endmodule

// File: rtl/alu.sv
// Top-level ALU: instruction decode, immediate extension and registered outputs.
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_datain,
    input  logic [31:0] gr1,
    input  logic [31:0] gr2,
    output logic [31:0] c,
    output logic [2:0]  zon,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic [31:0] reg_b;
    logic [4:0]  shamt;
    alu_sel_e    sel;
    logic [31:0] core_result;
    logic [2:0]  core_zon;
    logic [63:0] core_hilo;
    logic        core_hilo_we;
    logic        unused_reg_fields;

    assign opcode            = i_datain[31:26];
    assign funct             = i_datain[5:0];
    assign imm               = i_datain[15:0];
    assign imm_s             = {{16{imm[15]}}, imm};
    assign imm_z             = {16'h0000, imm};
    assign unused_reg_fields = ^i_datain[25:16];

    // Decode opcode/funct into an operation select and the B operand / shift amount
    always_comb begin
        sel   = ALU_INV;
        reg_b = gr2;
        shamt = i_datain[10:6];
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:   sel = ALU_ADD;
                    FN_ADDU:  sel = ALU_ADDU;
                    FN_SUB:   sel = ALU_SUB;
                    FN_SUBU:  sel = ALU_SUBU;
                    FN_AND:   sel = ALU_AND;
                    FN_OR:    sel = ALU_OR;
                    FN_XOR:   sel = ALU_XOR;
                    FN_NOR:   sel = ALU_NOR;
                    FN_SLT:   sel = ALU_SLT;
                    FN_SLTU:  sel = ALU_SLTU;
                    FN_SLL:   sel = ALU_SLL;
                    FN_SRL:   sel = ALU_SRL;
                    FN_SRA:   sel = ALU_SRA;
                    FN_SLLV: begin
                        sel   = ALU_SLL;
                        shamt = gr2[4:0];
                    end
                    FN_SRLV: begin
                        sel   = ALU_SRL;
                        shamt = gr2[4:0];
                    end
                    FN_SRAV: begin
                        sel   = ALU_SRA;
                        shamt = gr2[4:0];
                    end
                    FN_MULT:  sel = ALU_MULT;
                    FN_MULTU: sel = ALU_MULTU;
                    FN_DIV:   sel = ALU_DIV;
                    FN_DIVU:  sel = ALU_DIVU;
                    default:  sel = ALU_INV;
                endcase
            end
            OP_ADDI: begin
                sel   = ALU_ADD;
                reg_b = imm_s;
            end
            OP_ADDIU: begin
                sel   = ALU_ADDU;
                reg_b = imm_s;
            end
            OP_SLTI: begin
                sel   = ALU_SLT;
                reg_b = imm_s;
            end
            OP_SLTIU: begin
                sel   = ALU_SLTU;
                reg_b = imm_s;
            end
            OP_ANDI: begin
                sel   = ALU_AND;
                reg_b = imm_z;
            end
            OP_ORI: begin
                sel   = ALU_OR;
                reg_b = imm_z;
            end
            OP_XORI: begin
                sel   = ALU_XOR;
                reg_b = imm_z;
            end
            OP_LUI: begin
                sel   = ALU_LUI;
                reg_b = imm_z;
            end
            OP_BEQ, OP_BNE: begin
                sel   = ALU_SUB;
                reg_b = imm_s;
            end
            OP_LW, OP_SW: begin
                sel   = ALU_ADDU;
                reg_b = imm_s;
            end
            default: begin
                sel   = ALU_INV;
                reg_b = imm_s;
            end
        endcase
    end

    alu_core u_core (
        .reg_a   (gr1),
        .reg_b   (reg_b),
        .shamt   (shamt),
        .sel     (sel),
        .result  (core_result),
        .zon     (core_zon),
        .hilo    (core_hilo),
        .hilo_we (core_hilo_we)
    );

    // Output registers; hi/lo only load on multiply/divide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c   <= 32'd0;
            zon <= 3'b000;
            hi  <= 32'd0;
            lo  <= 32'd0;
        end else begin
            c   <= core_result;
            zon <= core_zon;
            if (core_hilo_we) begin
                hi <= core_hilo[63:32];
                lo <= core_hilo[31:0];
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal checks plus randomized stimulus
// compared every cycle against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] i_datain;
    logic [31:0] gr1;
    logic [31:0] gr2;
    logic [31:0] c;
    logic [2:0]  zon;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int fails;

    // Expected entry packing: {c[98:67], zon[66:64], hi[63:32], lo[31:0]}
    logic [98:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .i_datain (i_datain),
        .gr1      (gr1),
        .gr2      (gr2),
        .c        (c),
        .zon      (zon),
        .hi       (hi),
        .lo       (lo)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [98:0] model(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi_in,
                                          input logic [31:0] lo_in);
        logic [5:0]  op;
        logic [5:0]  fn;
        int          sh;
        longint      sa;
        longint      sb;
        longint      simm;
        longint      uimm;
        longint      full;
        logic [63:0] p;
        logic [31:0] res;
        logic [31:0] nhi;
        logic [31:0] nlo;
        logic        ovf;
        logic        signed_add;
        logic        signed_sub;
        op   = ins[31:26];
        fn   = ins[5:0];
        sh   = int'(ins[10:6]);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        simm = longint'($signed(ins[15:0]));
        uimm = longint'({16'h0, ins[15:0]});
        res  = 32'd0;
        nhi  = hi_in;
        nlo  = lo_in;
        ovf  = 1'b0;
        signed_add = 1'b0;
        signed_sub = 1'b0;
        full = 0;
        if (op == 6'h00) begin
            case (fn)
                6'h20: begin full = sa + sb; signed_add = 1'b1; end
                6'h21: full = sa + sb;
                6'h22: begin full = sa - sb; signed_sub = 1'b1; end
                6'h23: full = sa - sb;
                6'h24: full = longint'(a & b);
                6'h25: full = longint'(a | b);
                6'h26: full = longint'(a ^ b);
                6'h27: full = longint'(~(a | b));
                6'h2A: full = (sa < sb) ? 1 : 0;
                6'h2B: full = ({32'd0, a} < {32'd0, b}) ? 1 : 0;
                6'h00: full = longint'({32'd0, a}) * (longint'(1) << sh);
                6'h02: full = longint'({32'd0, a}) / (longint'(1) << sh);
                6'h03: full = sa >>> sh;
                6'h04: full = longint'({32'd0, a}) * (longint'(1) << b[4:0]);
                6'h06: full = longint'({32'd0, a}) / (longint'(1) << b[4:0]);
                6'h07: full = sa >>> b[4:0];
                6'h18: begin p = sa * sb; {nhi, nlo} = p; full = longint'(nlo); end
                6'h19: begin
                    p = {32'd0, a} * {32'd0, b};
                    {nhi, nlo} = p; full = longint'(nlo);
                end
                6'h1A: begin
                    if (b == 32'd0) begin nlo = 32'hFFFF_FFFF; nhi = a; end
                    else begin nlo = 32'(sa / sb); nhi = 32'(sa % sb); end
                    full = longint'(nlo);
                end
                6'h1B: begin
                    if (b == 32'd0) begin nlo = 32'hFFFF_FFFF; nhi = a; end
                    else begin nlo = a / b; nhi = a % b; end
                    full = longint'(nlo);
                end
                default: full = 0;
            endcase
        end else begin
            case (op)
                6'h08: begin full = sa + simm; signed_add = 1'b1; end
                6'h09, 6'h23, 6'h2B: full = sa + simm;
                6'h0A: full = (sa < simm) ? 1 : 0;
                6'h0B: full = ({32'd0, a} < 64'(32'(simm))) ? 1 : 0;
                6'h0C: full = longint'(a) & uimm;
                6'h0D: full = longint'(a) | uimm;
                6'h0E: full = longint'(a) ^ uimm;
                6'h0F: full = uimm * 65536;
                6'h04, 6'h05: begin full = sa - simm; signed_sub = 1'b1; end
                default: full = 0;
            endcase
        end
        res = full[31:0];
        if (signed_add || signed_sub)
            ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
        return {res, (res == 32'd0), ovf, res[31], nhi, nlo};
    endfunction

    // Model state advances on the same edges as the DUT
    always @(posedge clk or posedge rst) begin
        logic [98:0] e;
        if (rst) begin
            exp_q.delete();
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else begin
            e = model(i_datain, gr1, gr2, m_hi, m_lo);
            m_hi = e[63:32];
            m_lo = e[31:0];
            exp_q.push_back(e);
        end
    end

    // Compare process: every negedge outside reset, check the DUT against the model
    always @(negedge clk) begin
        logic [98:0] e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("model_c",   c,            e[98:67]);
            check("model_zon", {29'd0, zon}, {29'd0, e[66:64]});
            check("model_hi",  hi,           e[63:32]);
            check("model_lo",  lo,           e[31:0]);
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; applies one instruction and returns at the next negedge
    task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        i_datain = ins;
        gr1      = a;
        gr2      = b;
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [6];
        edges = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
        if ($urandom_range(0, 3) == 0)
            return edges[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    function automatic logic [31:0] pick_instr();
        logic [5:0] fns [20];
        logic [5:0] ops [13];
        logic [31:0] w;
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h18, 6'h19, 6'h1A, 6'h1B};
        ops = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F};
        w = $urandom();
        case ($urandom_range(0, 15))
            0:        return w;
            1, 2, 3, 4, 5, 6, 7, 8:
                      return {6'h00, w[25:6], fns[$urandom_range(0, 19)]};
            default:  return {ops[$urandom_range(0, 12)], w[25:0]};
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        i_datain = 32'd0;
        gr1      = 32'd0;
        gr2      = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("reset_c",   c,            32'd0);
        check("reset_zon", {29'd0, zon}, 32'd0);
        check("reset_hi",  hi,           32'd0);
        check("reset_lo",  lo,           32'd0);
        rst = 1'b0;

        // shifts
        apply(32'h0001_1040, 32'hDDDD_DDDD, 32'd0);
        check("sll1_c", c, 32'hBBBB_BBBA);
        check("sll1_zon", {29'd0, zon}, 32'd1);
        apply(32'h0001_1080, 32'hDDDD_DDDD, 32'd0);
        check("sll2_c", c, 32'h7777_7774);
        check("sll2_zon", {29'd0, zon}, 32'd0);
        apply(32'h0001_1040, 32'h4040_4040, 32'd0);
        check("sll_sign_c", c, 32'h8080_8080);
        check("sll_sign_zon", {29'd0, zon}, 32'd1);
        apply(32'h0001_1100, 32'h4040_6040, 32'd0);
        check("sll4_c", c, 32'h0406_0400);

        // add / addi / sub
        apply(32'h0000_0020, 32'hC040_4040, 32'hFFFF_FFFF);
        check("add_c", c, 32'hC040_403F);
        check("add_zon", {29'd0, zon}, 32'd1);
        apply(32'h0000_0020, 32'h7FFF_FFFF, 32'd1);
        check("add_ovf_c", c, 32'h8000_0000);
        check("add_ovf_zon", {29'd0, zon}, 32'd3);
        apply(32'h2000_00D0, 32'd1, 32'd0);
        check("addi_c", c, 32'h0000_00D1);
        check("addi_zon", {29'd0, zon}, 32'd0);
        apply(32'h0000_0022, 32'd5, 32'd5);
        check("sub_c", c, 32'd0);
        check("sub_zon", {29'd0, zon}, 32'd4);

        // multiply / divide
        apply(32'h0000_0018, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        apply(32'h0000_001A, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        apply(32'h0000_001B, 32'h1234_5678, 32'd0);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'h1234_5678);
        check("divu0_zon", {29'd0, zon}, 32'd1);
        apply(32'h0000_0020, 32'd3, 32'd4);
        check("hold_c", c, 32'd7);
        check("hold_hi", hi, 32'h1234_5678);
        check("hold_lo", lo, 32'hFFFF_FFFF);

        // unsupported funct
        apply(32'h0000_003F, 32'd9, 32'd9);
        check("inv_c", c, 32'd0);
        check("inv_zon", {29'd0, zon}, 32'd4);

        // asynchronous reset mid-cycle after a mult
        apply(32'h0000_0019, 32'h0001_0000, 32'h0001_0000);
        check("multu_hi", hi, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_c",   c,            32'd0);
        check("arst_zon", {29'd0, zon}, 32'd0);
        check("arst_hi",  hi,           32'd0);
        check("arst_lo",  lo,           32'd0);
        @(negedge clk);
        check("arst_hold_hi", hi, 32'd0);
        rst = 1'b0;
        #1;
        check("arst_rel_c", c, 32'd0);
        check("arst_rel_lo", lo, 32'd0);
        #3;
        @(negedge clk);

        // randomized traffic, checked by the compare process
        for (int i = 0; i < 600; i++)
            apply(pick_instr(), pick_operand(), pick_operand());

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
